// File: rtl/spin_sequencer.sv
// Roulette wheel spin sequencer.
// Accepts a spin request with a landing pocket, steps the lit LED around the
// wheel at a fixed fast period until the required laps are complete and the
// target is reached, then decelerates for one more full lap (the step period
// grows each step) and lands on the target.
// Ports:
//   clock, reset      - clock (rising edge), asynchronous active-high reset
//   spin_req, target  - spin request and landing pocket, sampled every edge
//   spin_ack          - one-cycle pulse, request accepted
//   spin_err          - one-cycle pulse, request rejected (target out of range)
//   led_number        - currently lit pocket
//   busy              - high while the wheel is moving
//   done              - one-cycle pulse, wheel has landed
//   result            - landed pocket, valid from done onward
module spin_sequencer #(
    parameter int unsigned NUM_POCKETS = 38,
    parameter int unsigned BASE_PERIOD = 2,
    parameter int unsigned PERIOD_INC  = 1,
    parameter int unsigned MIN_LAPS    = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spin_req,
    input  logic [5:0] target,
    output logic       spin_ack,
    output logic       spin_err,
    output logic [5:0] led_number,
    output logic       busy,
    output logic       done,
    output logic [5:0] result
);

    localparam int unsigned POS_W = 6;
    localparam int unsigned PER_W = 16;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned LAP_W = (MIN_LAPS < 1) ? 1 : $clog2(MIN_LAPS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        DECEL
    } state_t;

    state_t             state, state_d;
    logic [POS_W-1:0]   target_q, target_d;
    logic [PER_W-1:0]   timer, timer_d;
    logic [PER_W-1:0]   period, period_d;
    logic [LAP_W-1:0]   laps, laps_d;
    logic [CNT_W-1:0]   dcnt, dcnt_d;
    logic [POS_W-1:0]   led_d, result_d;
    logic               busy_d, done_d, ack_d, err_d;

    logic               step;
    logic [POS_W-1:0]   pos_next;
    logic [LAP_W-1:0]   laps_upd;
    logic [PER_W:0]     period_sum;
    logic [PER_W-1:0]   period_grown;
    logic [CNT_W-1:0]   dcnt_inc;

    // Step strobe, next wheel position, updated lap count, saturated period growth
    always_comb begin
        step         = (timer == period - PER_W'(1));
        pos_next     = (led_number == POS_W'(NUM_POCKETS - 1)) ? '0 : led_number + POS_W'(1);
        laps_upd     = ((pos_next == '0) && (laps < LAP_W'(MIN_LAPS))) ? laps + LAP_W'(1) : laps;
        period_sum   = {1'b0, period} + (PER_W + 1)'(PERIOD_INC);
        period_grown = period_sum[PER_W] ? '1 : period_sum[PER_W-1:0];
        dcnt_inc     = dcnt + CNT_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state;
        target_d = target_q;
        timer_d  = timer;
        period_d = period;
        laps_d   = laps;
        dcnt_d   = dcnt;
        led_d    = led_number;
        result_d = result;
        busy_d   = busy;
        done_d   = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        case (state)
            IDLE: begin
                if (spin_req) begin
                    // 7-bit compare so a NUM_POCKETS of 64 still rejects nothing wrongly
                    if ({1'b0, target} < CNT_W'(NUM_POCKETS)) begin
                        target_d = target;
                        timer_d  = '0;
                        laps_d   = '0;
                        dcnt_d   = '0;
                        period_d = PER_W'(BASE_PERIOD);
                        ack_d    = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = SPIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SPIN: begin
                if (step) begin
                    led_d   = pos_next;
                    timer_d = '0;
                    laps_d  = laps_upd;
                    if ((pos_next == target_q) && (laps_upd >= LAP_W'(MIN_LAPS))) begin
                        // First decel step already uses the incremented period
                        period_d = period_grown;
                        dcnt_d   = '0;
                        state_d  = DECEL;
                    end
                end else begin
                    timer_d = timer + PER_W'(1);
                end
            end

            DECEL: begin
                if (step) begin
                    led_d    = pos_next;
                    timer_d  = '0;
                    dcnt_d   = dcnt_inc;
                    period_d = period_grown;
                    // A full lap of decel steps lands back on the target
                    if (dcnt_inc == CNT_W'(NUM_POCKETS)) begin
                        done_d   = 1'b1;
                        result_d = target_q;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    timer_d = timer + PER_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target_q   <= '0;
            timer      <= '0;
            period     <= '0;
            laps       <= '0;
            dcnt       <= '0;
            led_number <= '0;
            result     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            spin_ack   <= 1'b0;
            spin_err   <= 1'b0;
        end else begin
            state      <= state_d;
            target_q   <= target_d;
            timer      <= timer_d;
            period     <= period_d;
            laps       <= laps_d;
            dcnt       <= dcnt_d;
            led_number <= led_d;
            result     <= result_d;
            busy       <= busy_d;
            done       <= done_d;
            spin_ack   <= ack_d;
            spin_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_spin_sequencer.sv
// Self-checking bench for spin_sequencer (default parameters).
// Expected landings are queued when a spin is requested and checked when done
// pulses; directed checks cover ack/err, step timing, reset and back-to-back.
module tb_spin_sequencer;

    localparam int unsigned NP = 38;
    localparam int unsigned BP = 2;
    localparam int unsigned PI = 1;
    localparam int unsigned ML = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       spin_req;
    logic [5:0] target;
    logic       spin_ack;
    logic       spin_err;
    logic [5:0] led_number;
    logic       busy;
    logic       done;
    logic [5:0] result;

    spin_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .spin_req   (spin_req),
        .target     (target),
        .spin_ack   (spin_ack),
        .spin_err   (spin_err),
        .led_number (led_number),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int unsigned tgt;
        int unsigned lat;
    } sb_t;

    sb_t         sb[$];
    int unsigned model_pos = 0;
    int unsigned ack_cyc   = 0;
    int unsigned done_cnt  = 0;
    int unsigned e0        = 0;

    // Independent wheel model: cycles from acceptance to landing
    function automatic int unsigned model_lat(input int unsigned start, input int unsigned tgt);
        int unsigned pos  = start;
        int unsigned laps = 0;
        int unsigned t    = 0;
        do begin
            pos = (pos + 1) % NP;
            t += BP;
            if (pos == 0 && laps < ML) laps++;
        end while (!(pos == tgt && laps >= ML));
        for (int k = 1; k <= int'(NP); k++) t += BP + k * PI;
        return t;
    endfunction

    // Scoreboard side: compare every landing against the queued expectation
    always @(negedge clock) begin
        if (!reset) begin
            if (spin_ack) ack_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_done", sb.size(), 1);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check_val("sb_result", result, e.tgt);
                    check_val("sb_led", led_number, e.tgt);
                    check_val("sb_latency", cyc - ack_cyc, e.lat);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        spin_req = 1'b0;
        target   = '0;
        tick(2);
        check_val("rst_led", led_number, 0);
        check_val("rst_result", result, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ack", spin_ack, 0);
        check_val("rst_err", spin_err, 0);
        reset = 1'b0;
        sb.delete();
        model_pos = 0;
    endtask

    task automatic start_spin(input logic [5:0] t);
        sb_t e;
        spin_req = 1'b1;
        target   = t;
        e.tgt    = t;
        e.lat    = model_lat(model_pos, t);
        sb.push_back(e);
        model_pos = t;
        tick(1);
        e0 = cyc;
        check_val("start_ack", spin_ack, 1);
        check_val("start_busy", busy, 1);
        check_val("start_err", spin_err, 0);
        spin_req = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output int unsigned lat);
        int unsigned n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        if (!done) check_val("done_timeout", done, 1);
        lat = cyc - e0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        int unsigned dc;
        sb_t         e;

        // Target 5 from reset: step timing, decel entry and landing
        do_reset();
        tick(1);
        start_spin(6'd5);
        tick(1);
        check_val("t5_led_e1", led_number, 0);
        tick(1);
        check_val("t5_led_e2", led_number, 1);
        tick(83);
        check_val("t5_led_e85", led_number, 4);
        tick(1);
        check_val("t5_led_e86", led_number, 5);
        check_val("t5_busy_e86", busy, 1);
        tick(2);
        check_val("t5_decel_hold_e88", led_number, 5);
        tick(1);
        check_val("t5_decel_step_e89", led_number, 6);
        wait_done(3000, lat);
        check_val("t5_latency", lat, 903);
        check_val("t5_result", result, 5);
        check_val("t5_busy_at_done", busy, 0);
        tick(1);
        check_val("t5_done_clears", done, 0);
        check_val("t5_led_holds", led_number, 5);
        check_val("t5_result_holds", result, 5);

        // Target 0 from reset
        do_reset();
        start_spin(6'd0);
        wait_done(3000, lat);
        check_val("t0_latency", lat, 893);
        tick(1);

        // Out-of-range targets rejected in IDLE
        spin_req = 1'b1;
        target   = 6'd40;
        tick(1);
        check_val("err40_err", spin_err, 1);
        check_val("err40_ack", spin_ack, 0);
        check_val("err40_busy", busy, 0);
        check_val("err40_led", led_number, 0);
        target = 6'd38;
        tick(1);
        check_val("err38_err", spin_err, 1);
        spin_req = 1'b0;
        tick(1);
        check_val("err_clears", spin_err, 0);
        check_val("err_busy", busy, 0);

        // Highest legal pocket; requests while busy are ignored
        start_spin(6'd37);
        tick(20);
        spin_req = 1'b1;
        target   = 6'd9;
        tick(1);
        check_val("busy_req_ack", spin_ack, 0);
        check_val("busy_req_err", spin_err, 0);
        target = 6'd40;
        tick(1);
        check_val("busy_bad_err", spin_err, 0);
        spin_req = 1'b0;
        wait_done(3000, lat);
        check_val("t37_latency", lat, 967);
        check_val("t37_result", result, 37);
        tick(1);

        // Reset mid-spin aborts without a landing
        start_spin(6'd20);
        tick(30);
        check_val("abort_busy_before", busy, 1);
        #3 reset = 1'b1;
        #1;
        check_val("abort_led", led_number, 0);
        check_val("abort_busy", busy, 0);
        tick(3);
        reset = 1'b0;
        sb.delete();
        model_pos = 0;
        dc = done_cnt;
        tick(5);
        check_val("abort_no_done", done_cnt, dc);
        check_val("abort_led_idle", led_number, 0);
        start_spin(6'd3);
        wait_done(3000, lat);
        check_val("after_abort_result", result, 3);
        tick(1);

        // Back-to-back with spin_req held high
        spin_req = 1'b1;
        target   = 6'd7;
        e.tgt = 7; e.lat = model_lat(3, 7); sb.push_back(e);
        e.tgt = 7; e.lat = model_lat(7, 7); sb.push_back(e);
        model_pos = 7;
        tick(1);
        e0 = cyc;
        check_val("b2b_ack1", spin_ack, 1);
        wait_done(3000, lat);
        check_val("b2b_ack_at_done", spin_ack, 0);
        tick(1);
        check_val("b2b_ack2", spin_ack, 1);
        check_val("b2b_done_clear", done, 0);
        check_val("b2b_busy2", busy, 1);
        e0 = cyc;
        spin_req = 1'b0;
        wait_done(3000, lat);
        check_val("b2b_latency2", lat, 893);
        tick(1);
        check_val("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spin_sequencer.md
SPIN_SEQUENCER -- requirements
Module: spin_sequencer

Interface
REQ-001 The block SHALL have parameters:
- NUM_POCKETS, 38, pocket count; legal positions 0..NUM_POCKETS-1 (0..36 plus 00 = 37).
- BASE_PERIOD, 2, clock cycles per wheel step during fast spin (>=1).
- PERIOD_INC, 1, cycles added to the step period on each deceleration step.
- MIN_LAPS, 1, full laps through position 0 required before landing is allowed.
REQ-002 The block SHALL have ports (one clock; reset is asynchronous and active-high):
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- spin_req, in, 1, request a spin; sampled every rising edge.
- target, in, 6, landing pocket, sampled with spin_req.
- spin_ack, out, 1, one-cycle pulse: request accepted.
- spin_err, out, 1, one-cycle pulse: request rejected, target >= NUM_POCKETS.
- led_number, out, 6, current lit pocket; feeds led_decoder and the regfile.
- busy, out, 1, high while SPIN or DECEL.
- done, out, 1, one-cycle pulse: wheel has landed.
- result, out, 6, landed pocket, valid from done onward.

Function
REQ-003 States SHALL be IDLE, SPIN, DECEL; all outputs registered.
REQ-004 In IDLE, spin_req=1 with target < NUM_POCKETS SHALL latch target, clear step timer and lap counter, load period = BASE_PERIOD, pulse spin_ack, and enter SPIN at that edge (edge E0).
REQ-005 In IDLE, spin_req=1 with target >= NUM_POCKETS SHALL pulse spin_err, stay in IDLE, and leave all other outputs unchanged.
REQ-006 spin_req while busy=1 SHALL be ignored: no ack, no err, no change to the latched target.
REQ-007 Step timer SHALL count 0..period-1. At timer == period-1 the block SHALL:
- advance led_number by 1, wrapping NUM_POCKETS-1 -> 0;
- reset the timer to 0.
The first step occurs at edge E0+BASE_PERIOD.
REQ-008 Each step that wraps to 0 SHALL increment the lap counter (saturating at MIN_LAPS); the landing check SHALL use the updated count.
REQ-009 In SPIN, a step whose new position equals target while laps >= MIN_LAPS SHALL enter DECEL. Arrival is checked only on steps, so a spin starting at target takes at least one full lap.
REQ-010 In DECEL, step k (k = 1..NUM_POCKETS) SHALL use period BASE_PERIOD + k*PERIOD_INC. The period register is 16 bits and saturates at 0xFFFF.
REQ-011 The NUM_POCKETS-th DECEL step lands on target again. At that edge the block SHALL set done=1 and result=target, clear busy, and return to IDLE. done clears at the next edge.
REQ-012 Total latency SHALL be T = sum of all step periods; done is high for the cycle between edges E0+T and E0+T+1.
REQ-013 A spin_req arriving in the same cycle that done is high SHALL be accepted, since the state is IDLE; spin_ack and done may coincide on consecutive edges without loss.
REQ-014 led_number SHALL hold its value in IDLE. The next spin starts from the last landed position.
REQ-015 Parameter arithmetic: the lap counter SHALL be wide enough for MIN_LAPS, and position compares SHALL be 6-bit unsigned.

Reset
REQ-016 While reset=1, asynchronously:
- state = IDLE;
- led_number = 0, result = 0;
- busy = 0, done = 0, spin_ack = 0, spin_err = 0;
- timer, lap counter and period = 0.
REQ-017 Reset mid-spin SHALL abort with no done pulse. The first spin after reset starts from position 0.

Verification (default parameters)
REQ-018 The bench SHALL cover these scenarios:
- Reset, then spin_req with target=5 at E0 -> spin_ack at E0; busy=1; first step 0->1 at E0+2; DECEL entry at E0+86; done=1, result=5, led_number=5 at E0+903.
- From reset, target=0 -> done at E0+893 (38+38 steps: 76+817 cycles).
- target=40 in IDLE -> spin_err pulse for 1 cycle; busy stays 0; led_number unchanged.
- During a busy spin, spin_req with target=9 -> ignored; landing still on the original target.
- reset asserted mid-SPIN -> led_number=0 and busy=0 immediately, with no done pulse; a new spin then starts from 0.
- Back-to-back: spin_req held high -> second spin accepted the edge after done, starting from the previous result.
